// File: rtl/axi4_stream_downsizer.sv
// AXI4-Stream width reducer: each wide input word is emitted as RATIO narrow beats,
// LSB chunk first; trailing empty chunks of a tlast word are skipped.
`timescale 1ns/1ps

module axi4_stream_downsizer #(
   parameter int RX_TDATA_WIDTH = 64,
   parameter int TX_TDATA_WIDTH = 16,
   parameter int TID_WIDTH      = 1,
   parameter int TDEST_WIDTH    = 1,
   parameter int TUSER_WIDTH    = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,

   input  logic [RX_TDATA_WIDTH-1:0]     pkt_i_tdata,
   input  logic [RX_TDATA_WIDTH/8-1:0]   pkt_i_tkeep,
   input  logic [RX_TDATA_WIDTH/8-1:0]   pkt_i_tstrb,
   input  logic                          pkt_i_tvalid,
   output logic                          pkt_i_tready,
   input  logic                          pkt_i_tlast,
   input  logic [TID_WIDTH-1:0]          pkt_i_tid,
   input  logic [TDEST_WIDTH-1:0]        pkt_i_tdest,
   input  logic [TUSER_WIDTH-1:0]        pkt_i_tuser,

   output logic [TX_TDATA_WIDTH-1:0]     pkt_o_tdata,
   output logic [TX_TDATA_WIDTH/8-1:0]   pkt_o_tkeep,
   output logic [TX_TDATA_WIDTH/8-1:0]   pkt_o_tstrb,
   output logic                          pkt_o_tvalid,
   input  logic                          pkt_o_tready,
   output logic                          pkt_o_tlast,
   output logic [TID_WIDTH-1:0]          pkt_o_tid,
   output logic [TDEST_WIDTH-1:0]        pkt_o_tdest,
   output logic [TUSER_WIDTH-1:0]        pkt_o_tuser
);

   localparam int RATIO     = RX_TDATA_WIDTH / TX_TDATA_WIDTH;
   localparam int RX_B      = RX_TDATA_WIDTH / 8;
   localparam int TX_B      = TX_TDATA_WIDTH / 8;
   localparam int IDX_WIDTH = (RATIO > 2) ? $clog2(RATIO) : 1;

   generate
      if ((RX_TDATA_WIDTH % 8 != 0) || (TX_TDATA_WIDTH % 8 != 0) ||
          (RX_TDATA_WIDTH % TX_TDATA_WIDTH != 0) || (RATIO < 2)) begin : g_param_check
         $error("axi4_stream_downsizer: RX_TDATA_WIDTH must be a multiple >= 2 of TX_TDATA_WIDTH, both multiples of 8");
      end
   endgenerate

   logic [RX_TDATA_WIDTH-1:0] word_tdata_reg;
   logic [RX_B-1:0]           word_tkeep_reg;
   logic [RX_B-1:0]           word_tstrb_reg;
   logic                      word_tlast_reg;
   logic [TID_WIDTH-1:0]      word_tid_reg;
   logic [TDEST_WIDTH-1:0]    word_tdest_reg;
   logic [TUSER_WIDTH-1:0]    word_tuser_reg;
   logic                      full_reg;
   logic [IDX_WIDTH-1:0]      idx_reg;
   logic [IDX_WIDTH-1:0]      last_idx_reg;
   logic [IDX_WIDTH-1:0]      last_idx_next;

   logic [TX_TDATA_WIDTH-1:0] chunk_tdata [RATIO];
   logic [TX_B-1:0]           chunk_tkeep [RATIO];
   logic [TX_B-1:0]           chunk_tstrb [RATIO];
   logic [RATIO-1:0]          rx_chunk_kept;

   logic rx_handshake;
   logic tx_handshake;
   logic at_last;

   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : g_chunk
         assign chunk_tdata[gi]   = word_tdata_reg[gi*TX_TDATA_WIDTH +: TX_TDATA_WIDTH];
         assign chunk_tkeep[gi]   = word_tkeep_reg[gi*TX_B +: TX_B];
         assign chunk_tstrb[gi]   = word_tstrb_reg[gi*TX_B +: TX_B];
         assign rx_chunk_kept[gi] = |pkt_i_tkeep[gi*TX_B +: TX_B];
      end
   endgenerate

   // Highest chunk holding a kept byte ends a tlast word; all-null tlast words still emit chunk 0.
   always_comb begin
      last_idx_next = IDX_WIDTH'(RATIO - 1);
      if (pkt_i_tlast) begin
         last_idx_next = '0;
         for (int i = 0; i < RATIO; i++) begin
            if (rx_chunk_kept[i]) begin
               last_idx_next = IDX_WIDTH'(i);
            end
         end
      end
   end

   assign at_last      = (idx_reg == last_idx_reg);
   assign pkt_i_tready = !full_reg || (pkt_o_tready && at_last);
   assign rx_handshake = pkt_i_tvalid && pkt_i_tready;
   assign tx_handshake = full_reg && pkt_o_tready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_tdata_reg <= '0;
         word_tkeep_reg <= '0;
         word_tstrb_reg <= '0;
         word_tlast_reg <= 1'b0;
         word_tid_reg   <= '0;
         word_tdest_reg <= '0;
         word_tuser_reg <= '0;
         full_reg       <= 1'b0;
         idx_reg        <= '0;
         last_idx_reg   <= '0;
      end else if (rx_handshake) begin
         // Also covers the refill on the final beat of the previous word, so no bubble.
         word_tdata_reg <= pkt_i_tdata;
         word_tkeep_reg <= pkt_i_tkeep;
         word_tstrb_reg <= pkt_i_tstrb;
         word_tlast_reg <= pkt_i_tlast;
         word_tid_reg   <= pkt_i_tid;
         word_tdest_reg <= pkt_i_tdest;
         word_tuser_reg <= pkt_i_tuser;
         full_reg       <= 1'b1;
         idx_reg        <= '0;
         last_idx_reg   <= last_idx_next;
      end else if (tx_handshake) begin
         if (at_last) begin
            full_reg <= 1'b0;
         end else begin
            idx_reg <= idx_reg + IDX_WIDTH'(1);
         end
      end
   end

   assign pkt_o_tvalid = full_reg;
   assign pkt_o_tdata  = chunk_tdata[idx_reg];
   assign pkt_o_tkeep  = chunk_tkeep[idx_reg];
   assign pkt_o_tstrb  = chunk_tstrb[idx_reg];
   assign pkt_o_tlast  = word_tlast_reg && at_last;
   assign pkt_o_tid    = word_tid_reg;
   assign pkt_o_tdest  = word_tdest_reg;
   assign pkt_o_tuser  = (idx_reg == '0) ? word_tuser_reg : '0;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Directed bench for axi4_stream_downsizer (64 -> 16 bit) with hand-computed expectations.
`timescale 1ns/1ps

module tb_axi4_stream_downsizer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [63:0] pkt_i_tdata;
   logic [7:0]  pkt_i_tkeep;
   logic [7:0]  pkt_i_tstrb;
   logic        pkt_i_tvalid;
   logic        pkt_i_tready;
   logic        pkt_i_tlast;
   logic [0:0]  pkt_i_tid;
   logic [0:0]  pkt_i_tdest;
   logic [0:0]  pkt_i_tuser;
   logic [15:0] pkt_o_tdata;
   logic [1:0]  pkt_o_tkeep;
   logic [1:0]  pkt_o_tstrb;
   logic        pkt_o_tvalid;
   logic        pkt_o_tready;
   logic        pkt_o_tlast;
   logic [0:0]  pkt_o_tid;
   logic [0:0]  pkt_o_tdest;
   logic [0:0]  pkt_o_tuser;

   always #5 clk = ~clk;

   axi4_stream_downsizer #(
      .RX_TDATA_WIDTH(64),
      .TX_TDATA_WIDTH(16),
      .TID_WIDTH(1),
      .TDEST_WIDTH(1),
      .TUSER_WIDTH(1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .pkt_i_tdata(pkt_i_tdata),
      .pkt_i_tkeep(pkt_i_tkeep),
      .pkt_i_tstrb(pkt_i_tstrb),
      .pkt_i_tvalid(pkt_i_tvalid),
      .pkt_i_tready(pkt_i_tready),
      .pkt_i_tlast(pkt_i_tlast),
      .pkt_i_tid(pkt_i_tid),
      .pkt_i_tdest(pkt_i_tdest),
      .pkt_i_tuser(pkt_i_tuser),
      .pkt_o_tdata(pkt_o_tdata),
      .pkt_o_tkeep(pkt_o_tkeep),
      .pkt_o_tstrb(pkt_o_tstrb),
      .pkt_o_tvalid(pkt_o_tvalid),
      .pkt_o_tready(pkt_o_tready),
      .pkt_o_tlast(pkt_o_tlast),
      .pkt_o_tid(pkt_o_tid),
      .pkt_o_tdest(pkt_o_tdest),
      .pkt_o_tuser(pkt_o_tuser)
   );

   int compared   = 0;
   int mismatched = 0;

   // Input word table and captured output beats.
   logic [63:0] in_data [8];
   logic [7:0]  in_keep [8];
   logic        in_last [8];
   logic [0:0]  in_id   [8];
   logic [0:0]  in_dest [8];
   logic [0:0]  in_user [8];
   int          n_in;

   logic [15:0] ob_data [64];
   logic [1:0]  ob_keep [64];
   logic [1:0]  ob_strb [64];
   logic        ob_last [64];
   logic [0:0]  ob_id   [64];
   logic [0:0]  ob_dest [64];
   logic [0:0]  ob_user [64];
   int          ob_cycle [64];
   int          rx_cycle [8];
   int          n_out;
   int          stable_err;
   bit          timeout;

   task automatic clear_inputs();
      pkt_i_tvalid = 1'b0;
      pkt_i_tdata  = '0;
      pkt_i_tkeep  = '0;
      pkt_i_tstrb  = '0;
      pkt_i_tlast  = 1'b0;
      pkt_i_tid    = '0;
      pkt_i_tdest  = '0;
      pkt_i_tuser  = '0;
   endtask

   // Drives the in_* table and records every output handshake with its cycle number.
   task automatic run_stream(input bit random_ready);
      int          i_idx;
      int          cyc;
      bit          all_in;
      bit          stalled;
      logic [15:0] s_data;
      logic [1:0]  s_keep;
      logic [1:0]  s_strb;
      logic        s_last;
      logic [0:0]  s_id;
      logic [0:0]  s_dest;
      logic [0:0]  s_user;
      i_idx      = 0;
      n_out      = 0;
      stable_err = 0;
      timeout    = 1'b1;
      stalled    = 1'b0;
      s_data = '0; s_keep = '0; s_strb = '0; s_last = 1'b0; s_id = '0; s_dest = '0; s_user = '0;
      for (cyc = 0; cyc < 400; cyc++) begin
         all_in = (i_idx >= n_in);
         @(negedge clk);
         if (all_in) begin
            clear_inputs();
         end else begin
            pkt_i_tvalid = 1'b1;
            pkt_i_tdata  = in_data[i_idx];
            pkt_i_tkeep  = in_keep[i_idx];
            pkt_i_tstrb  = in_keep[i_idx];
            pkt_i_tlast  = in_last[i_idx];
            pkt_i_tid    = in_id[i_idx];
            pkt_i_tdest  = in_dest[i_idx];
            pkt_i_tuser  = in_user[i_idx];
         end
         pkt_o_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled && (s_data !== pkt_o_tdata || s_keep !== pkt_o_tkeep || s_strb !== pkt_o_tstrb ||
                         s_last !== pkt_o_tlast || s_id !== pkt_o_tid || s_dest !== pkt_o_tdest ||
                         s_user !== pkt_o_tuser || pkt_o_tvalid !== 1'b1))
            stable_err++;
         if (all_in && !pkt_o_tvalid) begin
            timeout = 1'b0;
            break;
         end
         if (pkt_o_tvalid && pkt_o_tready && n_out < 64) begin
            ob_data[n_out]  = pkt_o_tdata;
            ob_keep[n_out]  = pkt_o_tkeep;
            ob_strb[n_out]  = pkt_o_tstrb;
            ob_last[n_out]  = pkt_o_tlast;
            ob_id[n_out]    = pkt_o_tid;
            ob_dest[n_out]  = pkt_o_tdest;
            ob_user[n_out]  = pkt_o_tuser;
            ob_cycle[n_out] = cyc;
            n_out++;
         end
         stalled = pkt_o_tvalid && !pkt_o_tready;
         s_data = pkt_o_tdata; s_keep = pkt_o_tkeep; s_strb = pkt_o_tstrb; s_last = pkt_o_tlast;
         s_id = pkt_o_tid; s_dest = pkt_o_tdest; s_user = pkt_o_tuser;
         if (pkt_i_tvalid && pkt_i_tready) begin
            rx_cycle[i_idx] = cyc;
            i_idx++;
         end
      end
      clear_inputs();
      pkt_o_tready = 1'b1;
   endtask

   task automatic set_word(input int w, input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [0:0] id, input logic [0:0] dest, input logic [0:0] user);
      in_data[w] = d;
      in_keep[w] = k;
      in_last[w] = l;
      in_id[w]   = id;
      in_dest[w] = dest;
      in_user[w] = user;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      clear_inputs();
      pkt_o_tready = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1;
      compared++;
      if (pkt_o_tvalid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_tvalid: got %b, expected 0", pkt_o_tvalid);
      end
      compared++;
      if (pkt_i_tready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_in_tready: got %b, expected 1", pkt_i_tready);
      end
      compared++;
      if ({pkt_o_tlast, pkt_o_tuser, pkt_o_tid, pkt_o_tdest} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_sideband: got last/user/id/dest=%b, expected 0000",
                  {pkt_o_tlast, pkt_o_tuser, pkt_o_tid, pkt_o_tdest});
      end
      $display("test_reset done");
   endtask

   task automatic test_full_word();
      logic [15:0] exp_d [4];
      exp_d[0] = 16'h2211; exp_d[1] = 16'h4433; exp_d[2] = 16'h6655; exp_d[3] = 16'h8877;
      n_in = 1;
      set_word(0, 64'h8877665544332211, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0);
      compared++;
      if (n_out !== 4) begin
         mismatched++;
         $display("FAIL full_word_count: got %0d beats, expected 4", n_out);
      end
      compared++;
      if (ob_cycle[0] !== rx_cycle[0] + 1) begin
         mismatched++;
         $display("FAIL full_word_latency: got cycle %0d, expected %0d", ob_cycle[0], rx_cycle[0] + 1);
      end
      for (int k = 0; k < 4 && k < n_out; k++) begin
         compared++;
         if (ob_data[k] !== exp_d[k] || ob_keep[k] !== 2'b11 || ob_strb[k] !== 2'b11 || ob_last[k] !== (k == 3)) begin
            mismatched++;
            $display("FAIL full_word_beat%0d: got data=%h keep=%b strb=%b last=%b, expected data=%h keep=11 strb=11 last=%b",
                     k, ob_data[k], ob_keep[k], ob_strb[k], ob_last[k], exp_d[k], (k == 3));
         end
      end
      $display("test_full_word: %0d beats", n_out);
   endtask

   task automatic test_partial_last();
      n_in = 1;
      set_word(0, 64'h8877665544332211, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0);
      compared++;
      if (n_out !== 2) begin
         mismatched++;
         $display("FAIL partial_count: got %0d beats, expected 2", n_out);
      end
      compared++;
      if (ob_data[0] !== 16'h2211 || ob_keep[0] !== 2'b11 || ob_last[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL partial_beat0: got data=%h keep=%b last=%b, expected 2211/11/0", ob_data[0], ob_keep[0], ob_last[0]);
      end
      compared++;
      if (ob_data[1] !== 16'h4433 || ob_keep[1] !== 2'b01 || ob_last[1] !== 1'b1) begin
         mismatched++;
         $display("FAIL partial_beat1: got data=%h keep=%b last=%b, expected 4433/01/1", ob_data[1], ob_keep[1], ob_last[1]);
      end
      $display("test_partial_last: %0d beats", n_out);
   endtask

   task automatic load_three_words();
      logic [63:0] d;
      n_in = 3;
      for (int w = 0; w < 3; w++) begin
         for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8 * w + b);
         set_word(w, d, 8'hFF, (w == 2), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d;
      load_three_words();
      run_stream(1'b0);
      compared++;
      if (n_out !== 12) begin
         mismatched++;
         $display("FAIL b2b_count: got %0d beats, expected 12", n_out);
      end
      compared++;
      if (rx_cycle[1] !== rx_cycle[0] + 4 || rx_cycle[2] !== rx_cycle[0] + 8) begin
         mismatched++;
         $display("FAIL b2b_accept_spacing: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                  rx_cycle[0], rx_cycle[1], rx_cycle[2], rx_cycle[0], rx_cycle[0] + 4, rx_cycle[0] + 8);
      end
      for (int k = 0; k < 12 && k < n_out; k++) begin
         exp_d = {8'(2 * k + 1), 8'(2 * k)};
         compared++;
         if (ob_data[k] !== exp_d || ob_last[k] !== (k == 11) || ob_cycle[k] !== ob_cycle[0] + k) begin
            mismatched++;
            $display("FAIL b2b_beat%0d: got data=%h last=%b cycle=%0d, expected data=%h last=%b cycle=%0d",
                     k, ob_data[k], ob_last[k], ob_cycle[k], exp_d, (k == 11), ob_cycle[0] + k);
         end
      end
      $display("test_back_to_back: %0d beats", n_out);
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_d;
      load_three_words();
      run_stream(1'b1);
      compared++;
      if (timeout !== 1'b0 || n_out !== 12) begin
         mismatched++;
         $display("FAIL bp_count: got %0d beats timeout=%b, expected 12 beats timeout=0", n_out, timeout);
      end
      compared++;
      if (stable_err !== 0) begin
         mismatched++;
         $display("FAIL bp_stable: got %0d unstable stall cycles, expected 0", stable_err);
      end
      for (int k = 0; k < 12 && k < n_out; k++) begin
         exp_d = {8'(2 * k + 1), 8'(2 * k)};
         compared++;
         if (ob_data[k] !== exp_d || ob_keep[k] !== 2'b11 || ob_last[k] !== (k == 11)) begin
            mismatched++;
            $display("FAIL bp_beat%0d: got data=%h keep=%b last=%b, expected data=%h keep=11 last=%b",
                     k, ob_data[k], ob_keep[k], ob_last[k], exp_d, (k == 11));
         end
      end
      $display("test_backpressure: %0d beats", n_out);
   endtask

   task automatic test_null_last();
      n_in = 1;
      set_word(0, 64'hA1A2A3A4A5A6A7A8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0);
      compared++;
      if (n_out !== 1) begin
         mismatched++;
         $display("FAIL null_count: got %0d beats, expected 1", n_out);
      end
      compared++;
      if (ob_data[0] !== 16'hA7A8 || ob_keep[0] !== 2'b00 || ob_last[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL null_beat: got data=%h keep=%b last=%b, expected a7a8/00/1", ob_data[0], ob_keep[0], ob_last[0]);
      end
      $display("test_null_last: %0d beats", n_out);
   endtask

   task automatic test_sideband();
      n_in = 1;
      set_word(0, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
      run_stream(1'b0);
      compared++;
      if (n_out !== 4) begin
         mismatched++;
         $display("FAIL side_count: got %0d beats, expected 4", n_out);
      end
      for (int k = 0; k < 4 && k < n_out; k++) begin
         compared++;
         if (ob_user[k] !== 1'((k == 0)) || ob_id[k] !== 1'b1 || ob_dest[k] !== 1'b1) begin
            mismatched++;
            $display("FAIL side_beat%0d: got user=%b id=%b dest=%b, expected user=%b id=1 dest=1",
                     k, ob_user[k], ob_id[k], ob_dest[k], (k == 0));
         end
      end
      $display("test_sideband: %0d beats", n_out);
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_d [4];
      exp_d[0] = 16'h7766; exp_d[1] = 16'h9988; exp_d[2] = 16'hBBAA; exp_d[3] = 16'hDDCC;
      @(negedge clk);
      pkt_o_tready = 1'b1;
      pkt_i_tvalid = 1'b1;
      pkt_i_tdata  = 64'h8877665544332211;
      pkt_i_tkeep  = 8'hFF;
      pkt_i_tstrb  = 8'hFF;
      pkt_i_tlast  = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1;
      compared++;
      if (pkt_o_tvalid !== 1'b1 || pkt_o_tdata !== 16'h2211) begin
         mismatched++;
         $display("FAIL rstmid_beat0: got valid=%b data=%h, expected 1/2211", pkt_o_tvalid, pkt_o_tdata);
      end
      @(negedge clk);
      #1;
      compared++;
      if (pkt_o_tvalid !== 1'b1 || pkt_o_tdata !== 16'h4433) begin
         mismatched++;
         $display("FAIL rstmid_beat1: got valid=%b data=%h, expected 1/4433", pkt_o_tvalid, pkt_o_tdata);
      end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      compared++;
      if (pkt_o_tvalid !== 1'b0 || pkt_i_tready !== 1'b1 || pkt_o_tlast !== 1'b0) begin
         mismatched++;
         $display("FAIL rstmid_state: got valid=%b in_ready=%b last=%b, expected 0/1/0",
                  pkt_o_tvalid, pkt_i_tready, pkt_o_tlast);
      end
      n_in = 1;
      set_word(0, 64'hDDCCBBAA99887766, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0);
      compared++;
      if (n_out !== 4) begin
         mismatched++;
         $display("FAIL rstmid_count: got %0d beats, expected 4", n_out);
      end
      for (int k = 0; k < 4 && k < n_out; k++) begin
         compared++;
         if (ob_data[k] !== exp_d[k] || ob_last[k] !== (k == 3)) begin
            mismatched++;
            $display("FAIL rstmid_beat%0d_after: got data=%h last=%b, expected data=%h last=%b",
                     k, ob_data[k], ob_last[k], exp_d[k], (k == 3));
         end
      end
      $display("test_reset_mid: %0d beats after reset", n_out);
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial_last();
      test_back_to_back();
      test_backpressure();
      test_null_last();
      test_sideband();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
